track_share_ctrl: RTL and testbench
===================================

TRACK_SHARE_CTRL -- requirements
Module: track_share_ctrl

Interface
REQ-001 SHALL have parameter N_TRAINS, default 2, number of trains/tracks sharing one common section (legal 2..8).
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum cycles an owner may hold the common section (legal 1..2**CNT_W-1).
REQ-003 SHALL have parameter CNT_W, default 8, watchdog counter width.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 SHALL have port Clock  input  1  rising-edge clock.
REQ-006 SHALL have port RESET_n  input  1  synchronous active-low reset.
REQ-007 SHALL have port SR_APPR  input  N_TRAINS  approach sensor per track, bit i high = train i requests the common section.
REQ-008 SHALL have port SR_EXIT  input  N_TRAINS  exit sensor per track, bit i high = train i has cleared the common section.
REQ-009 SHALL have port D  output  2*N_TRAINS  direction per train, D[2i+1:2i]: 2'b01 forward, 2'b00 stop.
REQ-010 SHALL have port SW  output  N_TRAINS  one-hot route switch, bit i set = track i connected to common section, all-zero = none.
REQ-011 SHALL have port OWNER  output  $clog2(N_TRAINS)  index of current owner, 0 when none.
REQ-012 SHALL have port BUSY  output  1  common section granted.
REQ-013 SHALL have port FAULT  output  1  watchdog fault latched.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT, FAULT; all outputs registered.
REQ-015 SHALL hold pending[i], set at each edge SR_APPR[i]=1, cleared at the edge train i is granted.
REQ-016 SHALL in IDLE, when (pending|SR_APPR)!=0, move to GRANT at that edge, selecting winner round-robin starting at (last_owner+1) mod N_TRAINS.
REQ-017 SHALL make grant visible after the first edge sampling the request: SW=one-hot(winner), OWNER=winner, BUSY=1 (latency 1 cycle).
REQ-018 SHALL drive D[i]=2'b00 for every train with pending set and not owner; all other trains 2'b01.
REQ-019 SHALL in GRANT return to IDLE at the edge SR_EXIT[owner]=1: SW=0, BUSY=0, OWNER retained as last_owner internally, OWNER output 0.
REQ-020 SHALL ignore SR_EXIT for non-owners and SR_APPR from the owner while in GRANT.
REQ-021 SHALL leave IDLE for at least one cycle between consecutive grants (no back-to-back handover).
REQ-022 SHALL, when SR_APPR[i] and SR_EXIT[i] are both high for owner i, process exit and set pending[i] again.
REQ-023 SHALL treat last_owner after reset as N_TRAINS-1 so train 0 wins first arbitration.

Reset
REQ-024 SHALL, at an edge with RESET_n=0, force state IDLE, pending=0, last_owner=N_TRAINS-1, counter=0, SW=0, OWNER=0, BUSY=0, FAULT=0, D all 2'b01.
REQ-025 SHALL give reset priority over every other event, including mid-GRANT and FAULT.

Configuration
REQ-026 SHALL compile watchdog logic only when macro TRACK_WATCHDOG_EN is defined.
REQ-027 SHALL with TRACK_WATCHDOG_EN: counter clears on entering GRANT, increments each GRANT cycle; when it reaches TIMEOUT without owner exit, move to FAULT: FAULT=1, SW=0, BUSY=0, D all 2'b00, held until reset.
REQ-028 SHALL with TRACK_WATCHDOG_EN: owner exit at the same edge as counter reaching TIMEOUT is processed as exit, not fault.
REQ-029 SHALL without TRACK_WATCHDOG_EN: no counter, FAULT tied 0, GRANT held indefinitely until owner exit.

Verification
REQ-030 SHALL cover reset: RESET_n=0 two cycles -> SW=0, BUSY=0, FAULT=0, D=all 2'b01.
REQ-031 SHALL cover single train: N=2, SR_APPR=2'b01 one cycle -> next cycle SW=2'b01, OWNER=0, BUSY=1; SR_EXIT=2'b01 -> SW=0, BUSY=0.
REQ-032 SHALL cover contention: SR_APPR=2'b11 -> train 0 granted, D[3:2]=2'b00; after exit of 0 and one idle cycle, SW=2'b10, D[3:2]=2'b01.
REQ-033 SHALL cover round-robin fairness: N=4, all SR_APPR held high -> grant order 0,1,2,3,0 over successive exits.
REQ-034 SHALL cover watchdog: TRACK_WATCHDOG_EN, TIMEOUT=4, grant train 1, no exit -> after 4 GRANT cycles FAULT=1, D all 2'b00; persists until RESET_n=0.
REQ-035 SHALL cover reset mid-GRANT: owner 1 active, RESET_n=0 one edge -> all outputs at reset values, next request from train 1 alone wins.

Source files
------------

// File: rtl/track_share_ctrl_if.sv
// Bus between the track-sharing controller and the track side.
//   SR_APPR  per-track approach sensors (track side -> controller)
//   SR_EXIT  per-track exit sensors     (track side -> controller)
//   D        2 bits per train: 2'b01 forward, 2'b00 stop
//   SW       one-hot route switch, all-zero = none connected
//   OWNER    index of current owner, 0 when none
//   BUSY     common section granted
//   FAULT    watchdog fault latched
// master = controller side, slave = track/sensor side.
interface track_share_ctrl_if #(
  parameter int unsigned N_TRAINS = 2
);
  localparam int unsigned OW = $clog2(N_TRAINS);

  logic [N_TRAINS-1:0]   SR_APPR;
  logic [N_TRAINS-1:0]   SR_EXIT;
  logic [2*N_TRAINS-1:0] D;
  logic [N_TRAINS-1:0]   SW;
  logic [OW-1:0]         OWNER;
  logic                  BUSY;
  logic                  FAULT;

  modport master (
    input  SR_APPR, SR_EXIT,
    output D, SW, OWNER, BUSY, FAULT
  );

  modport slave (
    output SR_APPR, SR_EXIT,
    input  D, SW, OWNER, BUSY, FAULT
  );
endinterface

// File: rtl/track_share_ctrl.sv
// Round-robin arbiter granting one common track section to N_TRAINS trains.
// Ports:
//   Clock    rising-edge clock
//   RESET_n  synchronous active-low reset
//   bus      track_share_ctrl_if.master (sensors in; D/SW/OWNER/BUSY/FAULT out)
// Optional feature: define TRACK_WATCHDOG_EN to add a hold-time watchdog that
// latches FAULT when an owner keeps the section for TIMEOUT cycles.
// Without it FAULT is tied 0 and a grant lasts until the owner exits.
module track_share_ctrl #(
  parameter int unsigned N_TRAINS = 2,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = 8
) (
  input logic              Clock,
  input logic              RESET_n,
  track_share_ctrl_if.master bus
);

  localparam int unsigned OW = $clog2(N_TRAINS);

  // Reject illegal configurations at elaboration.
  if (N_TRAINS < 2 || N_TRAINS > 8 || TIMEOUT < 1 || TIMEOUT >= (1 << CNT_W)) begin : g_bad_cfg
    $error("track_share_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, GRANT, FAULT} state_t;

  state_t                state;
  logic [N_TRAINS-1:0]   pending;
  logic [OW-1:0]         last_owner;
  logic [2*N_TRAINS-1:0] d_q;
  logic [N_TRAINS-1:0]   sw_q;
  logic [OW-1:0]         owner_q;
  logic                  busy_q;
  logic                  fault_q;
`ifdef TRACK_WATCHDOG_EN
  logic [CNT_W-1:0]      cnt_q;
`endif

  assign bus.D     = d_q;
  assign bus.SW    = sw_q;
  assign bus.OWNER = owner_q;
  assign bus.BUSY  = busy_q;
  assign bus.FAULT = fault_q;

  function automatic logic [N_TRAINS-1:0] onehot(input logic [OW-1:0] idx);
    return {{(N_TRAINS-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Stop every train in the mask, let all others run forward.
  function automatic logic [2*N_TRAINS-1:0] dvec(input logic [N_TRAINS-1:0] stop);
    logic [2*N_TRAINS-1:0] d;
    d = '0;
    for (int i = 0; i < N_TRAINS; i++) begin
      d[2*i +: 2] = stop[i] ? 2'b00 : 2'b01;
    end
    return d;
  endfunction

  logic [N_TRAINS-1:0] req_c;
  logic [N_TRAINS-1:0] owner_oh_c;
  logic [N_TRAINS-1:0] grant_pend_c;
  logic [N_TRAINS-1:0] hold_pend_c;
  logic [N_TRAINS-1:0] exit_pend_c;
  logic                exit_c;
  logic [OW-1:0]       winner_c;
  logic                found_c;

  assign req_c        = pending | bus.SR_APPR;
  assign owner_oh_c   = onehot(owner_q);
  assign exit_c       = |(bus.SR_EXIT & owner_oh_c);
  assign grant_pend_c = req_c & ~onehot(winner_c);
  // While granted, the owner's own approach sensor is ignored.
  assign hold_pend_c  = pending | (bus.SR_APPR & ~owner_oh_c);
  // On exit the owner may re-request in the same cycle.
  assign exit_pend_c  = pending | bus.SR_APPR;

  // Round-robin search starting one past the previous owner.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    winner_c = '0;
    found_c  = 1'b0;
    for (int k = 1; k <= N_TRAINS; k++) begin
      idx = int'(last_owner) + k;
      if (idx >= N_TRAINS) idx = idx - N_TRAINS;
      if (!found_c && req_c[OW'(idx)]) begin
        found_c  = 1'b1;
        winner_c = OW'(idx);
      end
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge Clock) begin
    if (!RESET_n) begin
      state      <= IDLE;
      pending    <= '0;
      last_owner <= OW'(N_TRAINS - 1);
      d_q        <= dvec('0);
      sw_q       <= '0;
      owner_q    <= '0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
`ifdef TRACK_WATCHDOG_EN
      cnt_q      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found_c) begin
            state   <= GRANT;
            sw_q    <= onehot(winner_c);
            owner_q <= winner_c;
            busy_q  <= 1'b1;
            pending <= grant_pend_c;
            d_q     <= dvec(grant_pend_c);
`ifdef TRACK_WATCHDOG_EN
            cnt_q   <= '0;
`endif
          end else begin
            pending <= req_c;
            d_q     <= dvec(req_c);
          end
        end
        GRANT: begin
          if (exit_c) begin
            state      <= IDLE;
            sw_q       <= '0;
            busy_q     <= 1'b0;
            owner_q    <= '0;
            last_owner <= owner_q;
            pending    <= exit_pend_c;
            d_q        <= dvec(exit_pend_c);
          end
`ifdef TRACK_WATCHDOG_EN
          else if (cnt_q + CNT_W'(1) == CNT_W'(TIMEOUT)) begin
            state   <= FAULT;
            sw_q    <= '0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            fault_q <= 1'b1;
            d_q     <= '0;
          end
`endif
          else begin
`ifdef TRACK_WATCHDOG_EN
            cnt_q   <= cnt_q + CNT_W'(1);
`endif
            pending <= hold_pend_c;
            d_q     <= dvec(hold_pend_c);
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_track_share_ctrl.sv
// Directed self-checking bench for track_share_ctrl: two-train, four-train and
// watchdog (TIMEOUT=4) instances sharing one clock and reset.
module tb_track_share_ctrl;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  track_share_ctrl_if #(.N_TRAINS(2)) i2 ();
  track_share_ctrl_if #(.N_TRAINS(4)) i4 ();
  track_share_ctrl_if #(.N_TRAINS(2)) iw ();

  track_share_ctrl #(.N_TRAINS(2)) u2 (.Clock(clk), .RESET_n(rst_n), .bus(i2));
  track_share_ctrl #(.N_TRAINS(4)) u4 (.Clock(clk), .RESET_n(rst_n), .bus(i4));
  track_share_ctrl #(.N_TRAINS(2), .TIMEOUT(4), .CNT_W(8)) uw (.Clock(clk), .RESET_n(rst_n), .bus(iw));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] oh4;
    logic [7:0] d4;
    int rr_order [5];
    n_checks = 0;
    n_fail   = 0;
    rr_order = '{0, 1, 2, 3, 0};
    i2.SR_APPR = '0; i2.SR_EXIT = '0;
    i4.SR_APPR = '0; i4.SR_EXIT = '0;
    iw.SR_APPR = '0; iw.SR_EXIT = '0;

    // Reset for two cycles.
    do_reset(2);
    check("rst_sw",    32'(i2.SW),    32'h0);
    check("rst_busy",  32'(i2.BUSY),  32'h0);
    check("rst_fault", 32'(i2.FAULT), 32'h0);
    check("rst_owner", 32'(i2.OWNER), 32'h0);
    check("rst_d2",    32'(i2.D),     32'h5);
    check("rst_d4",    32'(i4.D),     32'h55);

    // Single train request and exit.
    i2.SR_APPR = 2'b01; tick(); i2.SR_APPR = 2'b00;
    check("single_sw",    32'(i2.SW),    32'h1);
    check("single_owner", 32'(i2.OWNER), 32'h0);
    check("single_busy",  32'(i2.BUSY),  32'h1);
    check("single_d",     32'(i2.D),     32'h5);
    tick();
    check("single_hold", 32'(i2.SW), 32'h1);
    i2.SR_EXIT = 2'b01; tick(); i2.SR_EXIT = 2'b00;
    check("single_exit_sw",   32'(i2.SW),   32'h0);
    check("single_exit_busy", 32'(i2.BUSY), 32'h0);

    // Contention: both request, train 0 first, train 1 held stopped.
    do_reset(1);
    i2.SR_APPR = 2'b11; tick(); i2.SR_APPR = 2'b00;
    check("cont_sw0",    32'(i2.SW),    32'h1);
    check("cont_owner0", 32'(i2.OWNER), 32'h0);
    check("cont_d0",     32'(i2.D),     32'h1);
    i2.SR_EXIT = 2'b01; tick(); i2.SR_EXIT = 2'b00;
    check("cont_gap_busy", 32'(i2.BUSY), 32'h0);
    check("cont_gap_d",    32'(i2.D),    32'h1);
    tick();
    check("cont_sw1",    32'(i2.SW),    32'h2);
    check("cont_owner1", 32'(i2.OWNER), 32'h1);
    check("cont_d1",     32'(i2.D),     32'h5);
    // Exit of a non-owner is ignored.
    i2.SR_EXIT = 2'b01; tick(); i2.SR_EXIT = 2'b00;
    check("nonowner_exit_sw", 32'(i2.SW), 32'h2);
    // Owner approaches and exits together: exit processed and re-queued.
    i2.SR_APPR = 2'b10; i2.SR_EXIT = 2'b10; tick();
    i2.SR_APPR = 2'b00; i2.SR_EXIT = 2'b00;
    check("reappr_busy", 32'(i2.BUSY), 32'h0);
    check("reappr_d",    32'(i2.D),    32'h1);
    tick();
    check("reappr_sw", 32'(i2.SW), 32'h2);
    i2.SR_EXIT = 2'b10; tick(); i2.SR_EXIT = 2'b00;
    check("reappr_exit", 32'(i2.BUSY), 32'h0);

    // Round-robin with all four trains requesting continuously.
    i4.SR_APPR = 4'hF;
    for (int n = 0; n < 5; n++) begin
      oh4 = 4'b0001 << rr_order[n];
      d4  = 8'h00;
      for (int t = 0; t < 4; t++) if (oh4[t]) d4[2*t +: 2] = 2'b01;
      tick();
      check($sformatf("rr_owner_%0d", n), 32'(i4.OWNER), 32'(rr_order[n]));
      check($sformatf("rr_sw_%0d", n),    32'(i4.SW),    32'(oh4));
      check($sformatf("rr_d_%0d", n),     32'(i4.D),     32'(d4));
      i4.SR_EXIT = oh4; tick(); i4.SR_EXIT = 4'h0;
      check($sformatf("rr_gap_%0d", n), 32'(i4.BUSY), 32'h0);
    end
    i4.SR_APPR = 4'h0;

    // Owner exit on the same cycle the watchdog would expire.
    do_reset(1);
    iw.SR_APPR = 2'b10; tick(); iw.SR_APPR = 2'b00;
    check("wd_owner", 32'(iw.OWNER), 32'h1);
    for (int c = 0; c < 3; c++) tick();
    check("wd_pre_busy", 32'(iw.BUSY), 32'h1);
    iw.SR_EXIT = 2'b10; tick(); iw.SR_EXIT = 2'b00;
    check("wd_race_fault", 32'(iw.FAULT), 32'h0);
    check("wd_race_busy",  32'(iw.BUSY),  32'h0);

    // Hold the section with no exit for four grant cycles.
    iw.SR_APPR = 2'b10; tick(); iw.SR_APPR = 2'b00;
    check("wd2_owner", 32'(iw.OWNER), 32'h1);
    for (int c = 0; c < 3; c++) tick();
    check("wd2_pre_fault", 32'(iw.FAULT), 32'h0);
    tick();
`ifdef TRACK_WATCHDOG_EN
    check("wd_fault", 32'(iw.FAULT), 32'h1);
    check("wd_d",     32'(iw.D),     32'h0);
    check("wd_sw",    32'(iw.SW),    32'h0);
    check("wd_busy",  32'(iw.BUSY),  32'h0);
    iw.SR_APPR = 2'b11; iw.SR_EXIT = 2'b10; tick(); tick();
    iw.SR_APPR = 2'b00; iw.SR_EXIT = 2'b00;
    check("wd_sticky", 32'(iw.FAULT), 32'h1);
`else
    check("nowd_fault", 32'(iw.FAULT), 32'h0);
    check("nowd_busy",  32'(iw.BUSY),  32'h1);
    for (int c = 0; c < 20; c++) tick();
    check("nowd_hold_sw", 32'(iw.SW),    32'h2);
    check("nowd_fault2",  32'(iw.FAULT), 32'h0);
    iw.SR_EXIT = 2'b10; tick(); iw.SR_EXIT = 2'b00;
    check("nowd_exit", 32'(iw.BUSY), 32'h0);
`endif
    do_reset(1);
    check("wd_rst_fault", 32'(iw.FAULT), 32'h0);
    check("wd_rst_d",     32'(iw.D),     32'h5);

    // Reset in the middle of a grant to train 1.
    i2.SR_APPR = 2'b10; tick(); i2.SR_APPR = 2'b00;
    check("mid_owner", 32'(i2.OWNER), 32'h1);
    do_reset(1);
    check("mid_rst_sw",    32'(i2.SW),    32'h0);
    check("mid_rst_busy",  32'(i2.BUSY),  32'h0);
    check("mid_rst_owner", 32'(i2.OWNER), 32'h0);
    check("mid_rst_d",     32'(i2.D),     32'h5);
    check("mid_rst_fault", 32'(i2.FAULT), 32'h0);
    i2.SR_APPR = 2'b10; tick(); i2.SR_APPR = 2'b00;
    check("mid_regrant_owner", 32'(i2.OWNER), 32'h1);
    check("mid_regrant_sw",    32'(i2.SW),    32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
